uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1, LSB first, idle-high line. It is the receive-side counterpart of `uart_tx` and sits between the external RX pin and the AXI-Lite UART register wrapper. It synchronises the pin, detects and qualifies the start bit, and samples each bit at mid-period. Each byte is delivered as a one-cycle `rx_valid` pulse, or flagged with a `frame_err` pulse.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_if.sv | 26 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants, used by uart_rx and uart_tx.
// Provides the rx FSM state enum and the baud divisor helper.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int CNT_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    function automatic int bps_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bundle from uart_rx to its consumer.
// Ports: rx_data, rx_valid, frame_err, busy (all driven by master).
interface uart_rx_if
    import uart_pkg::*;
();

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input frame_err,
        input busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with parameterised reset value.
// Ports: clk, rst_n, d (async in), q (synchronised out).
module sync_2ff #(
    parameter int         W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling.
// Ports: clk, rst_n, RX (raw pin), rx_bus (rx_data/rx_valid/frame_err/busy).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 9600
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      RX,
    uart_rx_if.master rx_bus
);

    localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
    localparam int HALF    = BPS_CNT / 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    if (BPS_CNT < 4 || BPS_CNT > 65535) begin : g_bad_bps
        $error("uart_rx: BPS_CNT out of range 4..65535");
    end

    logic rx_s;
    logic rx_d;
    logic fall;

    // Flops reset to 1, so their content is fake until the pin has
    // propagated through; only arm edge detection once a real high
    // has been seen, so a line held low across reset is ignored.
    logic [1:0] warm;
    logic       armed;

    uart_rx_state_t state, state_n;

    logic [CNT_W-1:0]     clk_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    logic cnt_last;
    logic cnt_mid;
    logic shift;
    logic load;
    logic err;

    sync_2ff #(
        .W       (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (RX),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_d  <= 1'b1;
            warm  <= 2'd0;
            armed <= 1'b0;
        end else begin
            rx_d <= rx_s;
            if (warm != 2'd3) begin
                warm <= warm + 2'd1;
            end
            if (warm == 2'd3 && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign fall     = armed & rx_d & ~rx_s;
    assign cnt_last = (clk_cnt == CNT_LAST);
    assign cnt_mid  = (clk_cnt == CNT_MID);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        shift   = 1'b0;
        load    = 1'b0;
        err     = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt_mid) begin
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_last) begin
                    shift = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                // Leave at mid-stop so a back-to-back start is caught.
                if (cnt_last) begin
                    if (rx_s) begin
                        load    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        err     = 1'b1;
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt          <= '0;
            bit_cnt          <= '0;
            shreg            <= '0;
            rx_bus.rx_data   <= '0;
            rx_bus.rx_valid  <= 1'b0;
            rx_bus.frame_err <= 1'b0;
        end else begin
            if (state_n != state || state == IDLE || cnt_last) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
            if (state != DATA) begin
                bit_cnt <= '0;
            end else if (shift) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (shift) begin
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            end
            if (load) begin
                rx_bus.rx_data <= shreg;
            end
            rx_bus.rx_valid  <= load;
            rx_bus.frame_err <= err;
        end
    end

    assign rx_bus.busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at BPS_CNT = 10.
// A behavioural transmitter drives RX; a monitor logs pulses.
module tb_uart_rx;

    logic clk;
    logic rst_n;
    logic RX;

    uart_rx_if u_if ();

    uart_rx #(
        .CLK_FREQ (50_000_000),
        .UART_BPS (5_000_000)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .RX     (RX),
        .rx_bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    logic [7:0] q[$];
    int         err_cnt;
    int         both_cnt;
    int         busy_cyc;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.rx_valid) q.push_back(u_if.rx_data);
            if (u_if.frame_err) err_cnt++;
            if (u_if.rx_valid && u_if.frame_err) both_cnt++;
            if (u_if.busy) busy_cyc++;
        end
    end

    // Bit period given in tenths of a clock; bit k starts at the
    // negedge nearest k*pt/10 after the start edge.
    task automatic send_frame(input logic [7:0] d, input int pt,
                              input logic stop_v, input int nbits);
        logic [9:0] fr;
        fr = {stop_v, d, 1'b0};
        for (int k = 0; k < nbits; k++) begin
            RX = fr[k];
            repeat (((k + 1) * pt + 5) / 10 - (k * pt + 5) / 10)
                @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int lat;
    bit got_v;

    initial begin
        tests    = 0;
        fails    = 0;
        err_cnt  = 0;
        both_cnt = 0;
        busy_cyc = 0;
        RX       = 1'b1;
        rst_n    = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        check("rst_data", u_if.rx_data, 8'h00);
        check("rst_valid", u_if.rx_valid, 0);
        check("rst_ferr", u_if.frame_err, 0);
        check("rst_busy", u_if.busy, 0);

        // back-to-back frames
        q.delete();
        send_frame(8'hA5, 100, 1'b1, 10);
        send_frame(8'h00, 100, 1'b1, 10);
        send_frame(8'hFF, 100, 1'b1, 10);
        send_frame(8'h5A, 100, 1'b1, 10);
        idle(30);
        check("b2b_count", q.size(), 4);
        if (q.size() == 4) begin
            check("b2b_0", q[0], 8'hA5);
            check("b2b_1", q[1], 8'h00);
            check("b2b_2", q[2], 8'hFF);
            check("b2b_3", q[3], 8'h5A);
        end
        check("b2b_ferr", err_cnt, 0);

        // glitch shorter than half a bit
        q.delete();
        busy_cyc = 0;
        RX = 1'b0;
        repeat (3) @(negedge clk);
        idle(30);
        check("glitch_valid", q.size(), 0);
        check("glitch_busy_cyc", busy_cyc, 5);
        check("glitch_idle", u_if.busy, 0);

        // framing error followed by a break
        q.delete();
        send_frame(8'h3C, 100, 1'b0, 10);
        RX = 1'b0;
        repeat (30) @(negedge clk);
        idle(30);
        check("ferr_count", err_cnt, 1);
        check("ferr_novalid", q.size(), 0);
        check("ferr_hold", u_if.rx_data, 8'h5A);
        send_frame(8'h81, 100, 1'b1, 10);
        idle(30);
        check("after_ferr_cnt", q.size(), 1);
        if (q.size() == 1) check("after_ferr_data", q[0], 8'h81);
        check("after_ferr_err", err_cnt, 1);

        // transmitter 4% fast then 4% slow
        q.delete();
        send_frame(8'hC3, 96, 1'b1, 10);
        idle(30);
        check("fast_cnt", q.size(), 1);
        if (q.size() == 1) check("fast_data", q[0], 8'hC3);
        q.delete();
        send_frame(8'hC3, 104, 1'b1, 10);
        idle(30);
        check("slow_cnt", q.size(), 1);
        if (q.size() == 1) check("slow_data", q[0], 8'hC3);

        // reset during data bit 4
        q.delete();
        send_frame(8'h96, 100, 1'b1, 5);
        RX = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", u_if.rx_data, 8'h00);
        check("mid_rst_valid", u_if.rx_valid, 0);
        check("mid_rst_ferr", u_if.frame_err, 0);
        check("mid_rst_busy", u_if.busy, 0);
        RX = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        check("mid_rst_nopulse", q.size(), 0);
        send_frame(8'h96, 100, 1'b1, 10);
        idle(30);
        check("post_rst_cnt", q.size(), 1);
        if (q.size() == 1) check("post_rst_data", q[0], 8'h96);

        // exact latency: 2 sync + 5 + 90 + 1
        q.delete();
        lat   = 0;
        got_v = 1'b0;
        fork
            send_frame(8'h01, 100, 1'b1, 10);
            begin
                for (int n = 1; n <= 200 && !got_v; n++) begin
                    @(negedge clk);
                    if (u_if.rx_valid) begin
                        got_v = 1'b1;
                        lat   = n;
                    end
                end
            end
        join
        idle(20);
        check("lat_seen", got_v, 1);
        check("lat_cycles", lat, 98);
        check("lat_cnt", q.size(), 1);
        if (q.size() == 1) check("lat_data", q[0], 8'h01);

        check("never_both", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
